// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU.
//   aluop_t        : opcode encodings, including SRA (10) and MUL (11)
//   alu_flags_t    : status flags carried alongside every result
//   mul_st_e       : multiplier pre-stage states (used only when ALU_MUL_EN is defined)
//   ILLEGAL_RESULT : result presented for unimplemented opcodes (sliced to WIDTH by users)
// The per-stage payload depends on the WIDTH/TAG_W parameters of each instance, so it is
// declared inside alu_pipe and is built from alu_flags_t.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_MUL  = 4'd11
  } aluop_t;

  typedef struct packed {
    logic negative;
    logic overflow;
    logic zero;
    logic illegal;
  } alu_flags_t;

  typedef enum logic [1:0] {StIdle, StRun, StDone} mul_st_e;

  // Wide enough for the largest supported datapath.
  localparam logic [63:0] ILLEGAL_RESULT = '0;

endpackage

// File: rtl/alu_exec_core.sv
// Combinational ALU core: computes result and flags for one operation.
//   a, b   : operands
//   op     : opcode (aluop_t encoding)
//   result : WIDTH-bit result (ILLEGAL_RESULT for unimplemented opcodes)
//   flags  : negative / overflow / zero / illegal
// With ALU_MUL_EN defined, op 11 is legal here but its result comes from the multiplier.
module alu_exec_core
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  localparam int unsigned ShW = $clog2(WIDTH);

  logic [ShW-1:0]   shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf;
  logic             ill;

  assign shamt = b[ShW-1:0];
  assign sum   = a + b;
  assign diff  = a - b;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    ill    = 1'b0;
    case (op)
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_ADD: begin
        result = sum;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        // Same rule as ADD with B inverted: operand signs must differ.
        result = diff;
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_MUL_EN
      ALU_MUL:  result = '0;
`endif
      default: begin
        result = ILLEGAL_RESULT[WIDTH-1:0];
        ill    = 1'b1;
      end
    endcase
    flags.negative = result[WIDTH-1];
    flags.overflow = ovf;
    flags.zero     = (result == '0);
    flags.illegal  = ill;
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshakes, sideband tag and flush.
//   CLK, nRST              : clock (rising edge), asynchronous active-low reset
//   flush                  : drop every in-flight op at the next edge
//   in_valid/in_ready      : input handshake for port_A, port_B, aluop, in_tag
//   out_valid/out_ready    : output handshake for output_port, flags and out_tag
// Stage 1 registers the combinational core result; stages 2..LATENCY carry the payload.
// Optional feature macro ALU_MUL_EN: op 11 becomes a WIDTH-cycle shift-add multiply in a
// pre-stage ahead of stage 1; without it op 11 is illegal and no multiplier exists.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] port_A,
  input  logic [WIDTH-1:0] port_B,
  input  logic [3:0]       aluop,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_port,
  output logic             negative,
  output logic             overflow,
  output logic             zero,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    alu_flags_t       flags;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;
  stage_t           s1_pl;
  logic             s1_valid;
  logic             accept;
  logic             mul_idle;
  logic             all_full;

  logic [LATENCY:1] v_q;
  logic [LATENCY:1] take;
  stage_t           pl_q [LATENCY:1];

  alu_exec_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (port_A),
    .b      (port_B),
    .op     (aluop),
    .result (core_result),
    .flags  (core_flags)
  );

  // Stage k can take new data if the output is draining or a bubble exists at or after k.
  always_comb begin
    take     = '0;
    all_full = 1'b1;
    for (int k = 1; k <= int'(LATENCY); k++) begin
      all_full = 1'b1;
      for (int j = k; j <= int'(LATENCY); j++) all_full = all_full & v_q[j];
      take[k] = out_ready || !all_full;
    end
  end

  assign in_ready = !flush && take[1] && mul_idle;
  assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
  localparam int unsigned CntW = $clog2(WIDTH);

  mul_st_e            mul_st_q, mul_st_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [TAG_W-1:0]   mtag_q, mtag_d;
  logic               is_mul;

  assign is_mul   = (aluop == ALU_MUL);
  assign mul_idle = (mul_st_q == StIdle);

  // The first partial product is taken at accept, so WIDTH-1 further steps remain.
  always_comb begin
    mul_st_d = mul_st_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    mtag_d   = mtag_q;
    case (mul_st_q)
      StIdle: begin
        if (accept && is_mul) begin
          acc_d    = port_B[0] ? {{WIDTH{1'b0}}, port_A} : '0;
          mcand_d  = {{(WIDTH-1){1'b0}}, port_A, 1'b0};
          mplier_d = port_B >> 1;
          cnt_d    = CntW'(1);
          mtag_d   = in_tag;
          mul_st_d = StRun;
        end
      end
      StRun: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) mul_st_d = StDone;
      end
      StDone: begin
        if (take[1]) mul_st_d = StIdle;
      end
      default: mul_st_d = StIdle;
    endcase
    if (flush) mul_st_d = StIdle;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mul_st_q <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      mtag_q   <= '0;
    end else begin
      mul_st_q <= mul_st_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      mtag_q   <= mtag_d;
    end
  end

  // in_ready is low while the multiplier is busy, so a finished product never races an input.
  always_comb begin
    s1_pl    = '0;
    s1_valid = 1'b0;
    if (mul_st_q == StDone) begin
      s1_valid                = 1'b1;
      s1_pl.result            = acc_q[WIDTH-1:0];
      s1_pl.flags.negative    = acc_q[WIDTH-1];
      s1_pl.flags.overflow    = |acc_q[2*WIDTH-1:WIDTH];
      s1_pl.flags.zero        = (acc_q[WIDTH-1:0] == '0);
      s1_pl.flags.illegal     = 1'b0;
      s1_pl.tag               = mtag_q;
    end else begin
      s1_valid     = accept && !is_mul;
      s1_pl.result = core_result;
      s1_pl.flags  = core_flags;
      s1_pl.tag    = in_tag;
    end
  end
`else
  assign mul_idle = 1'b1;

  always_comb begin
    s1_pl        = '0;
    s1_valid     = accept;
    s1_pl.result = core_result;
    s1_pl.flags  = core_flags;
    s1_pl.tag    = in_tag;
  end
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      v_q <= '0;
      for (int k = 1; k <= int'(LATENCY); k++) pl_q[k] <= '0;
    end else if (flush) begin
      v_q <= '0;
    end else begin
      if (take[1]) begin
        v_q[1] <= s1_valid;
        if (s1_valid) pl_q[1] <= s1_pl;
      end
      for (int k = 2; k <= int'(LATENCY); k++) begin
        if (take[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) pl_q[k] <= pl_q[k-1];
        end
      end
    end
  end

  assign out_valid   = v_q[LATENCY];
  assign output_port = pl_q[LATENCY].result;
  assign negative    = pl_q[LATENCY].flags.negative;
  assign overflow    = pl_q[LATENCY].flags.overflow;
  assign zero        = pl_q[LATENCY].flags.zero;
  assign illegal     = pl_q[LATENCY].flags.illegal;
  assign out_tag     = pl_q[LATENCY].tag;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a LATENCY=3 instance for most steps and a LATENCY=2
// instance for the basic latency step. Honours ALU_MUL_EN for the op 11 steps.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST, flush, in_valid, in_valid2, out_ready;
  logic [31:0] port_A, port_B;
  logic [3:0]  aluop;
  logic [4:0]  in_tag;

  logic        in_ready, out_valid, negative, overflow, zero, illegal;
  logic [31:0] output_port;
  logic [4:0]  out_tag;
  logic        in_ready2, out_valid2, negative2, overflow2, zero2, illegal2;
  logic [31:0] output_port2;
  logic [4:0]  out_tag2;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  alu_pipe #(.WIDTH(32), .LATENCY(3), .TAG_W(5)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .port_A(port_A), .port_B(port_B), .aluop(aluop), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .output_port(output_port),
    .negative(negative), .overflow(overflow), .zero(zero), .illegal(illegal),
    .out_tag(out_tag)
  );

  alu_pipe #(.WIDTH(32), .LATENCY(2), .TAG_W(5)) dut2 (
    .CLK(CLK), .nRST(nRST), .flush(flush), .in_valid(in_valid2), .in_ready(in_ready2),
    .port_A(port_A), .port_B(port_B), .aluop(aluop), .in_tag(in_tag),
    .out_valid(out_valid2), .out_ready(out_ready), .output_port(output_port2),
    .negative(negative2), .overflow(overflow2), .zero(zero2), .illegal(illegal2),
    .out_tag(out_tag2)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Issue one op with out_ready=1 and wait (bounded) for out_valid; lat=0 means timeout.
  task automatic do_op(input bit use2, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       output int lat, output bit rdy_low);
    @(posedge CLK); #1;
    aluop = op; port_A = a; port_B = b; in_tag = tag; out_ready = 1'b1;
    if (use2) in_valid2 = 1'b1; else in_valid = 1'b1;
    @(negedge CLK);
    chk("accept_ready", 64'(use2 ? in_ready2 : in_ready), 64'd1);
    @(posedge CLK); #1;
    in_valid = 1'b0; in_valid2 = 1'b0;
    lat = 0; rdy_low = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge CLK);
      if (!(use2 ? in_ready2 : in_ready)) rdy_low = 1'b1;
      if (use2 ? out_valid2 : out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run(input string name, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] tag, input logic [31:0] res,
                     input logic [3:0] nozi, input int exp_lat, input bit exp_rdy_low);
    int lat;
    bit rl;
    do_op(1'b0, op, a, b, tag, lat, rl);
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_ready_low"}, 64'(rl), 64'(exp_rdy_low));
    chk({name, "_res"}, 64'(output_port), 64'(res));
    chk({name, "_flags_nozi"}, 64'({negative, overflow, zero, illegal}), 64'(nozi));
    chk({name, "_tag"}, 64'(out_tag), 64'(tag));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc_cnt, tag_n, exp_tag, first_c, last_c, stale;
    bit rl, acc;
    nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0;
    port_A = '0; port_B = '0; aluop = '0; in_tag = '0;

    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_output_port", 64'(output_port), 64'd0);
    chk("rst_flags_tag", 64'({negative, overflow, zero, illegal, out_tag}), 64'd0);
    @(negedge CLK); nRST = 1'b1;
    @(negedge CLK);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // LATENCY=2 instance: signed ADD overflow.
    do_op(1'b1, 4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3, lat, rl);
    chk("add2_lat", 64'(lat), 64'd2);
    chk("add2_res", 64'(output_port2), 64'h8000_0000);
    chk("add2_flags_nozi", 64'({negative2, overflow2, zero2, illegal2}), 64'b1100);
    chk("add2_tag", 64'(out_tag2), 64'd3);

    // LATENCY=3 instance, directed vectors. Flags are {negative, overflow, zero, illegal}.
    run("sub_eq",  4'd3,  32'h0000_1234, 32'h0000_1234, 5'd1,  32'h0000_0000, 4'b0010, 3, 0);
    run("slt",     4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 5'd2,  32'h0000_0001, 4'b0000, 3, 0);
    run("sltu",    4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 5'd3,  32'h0000_0000, 4'b0010, 3, 0);
    run("sra",     4'd10, 32'h8000_0000, 32'h0000_0004, 5'd4,  32'hF800_0000, 4'b1000, 3, 0);
    run("sub_ovf", 4'd3,  32'h8000_0000, 32'h0000_0001, 5'd5,  32'h7FFF_FFFF, 4'b0100, 3, 0);
    run("sll_b35", 4'd0,  32'h0000_0001, 32'h0000_0023, 5'd6,  32'h0000_0008, 4'b0000, 3, 0);
    run("srl_31",  4'd1,  32'h8000_0000, 32'h0000_001F, 5'd7,  32'h0000_0001, 4'b0000, 3, 0);
    run("nor",     4'd7,  32'h0000_0000, 32'h0000_0000, 5'd8,  32'hFFFF_FFFF, 4'b1000, 3, 0);
    run("xor",     4'd6,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd9,  32'h0FF0_0FF0, 4'b0000, 3, 0);
    run("and",     4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd10, 32'hF000_F000, 4'b1000, 3, 0);
    run("or",      4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd11, 32'hFFF0_FFF0, 4'b1000, 3, 0);
    run("add_m1",  4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 5'd12, 32'h0000_0000, 4'b0010, 3, 0);
    run("ill_14",  4'd14, 32'h0000_0005, 32'h0000_0007, 5'd13, 32'h0000_0000, 4'b0011, 3, 0);
`ifdef ALU_MUL_EN
    run("mul_ovf", 4'd11, 32'h0001_0000, 32'h0001_0000, 5'd14, 32'h0000_0000, 4'b0110, 35, 1);
    run("mul_3x5", 4'd11, 32'h0000_0003, 32'h0000_0005, 5'd15, 32'h0000_000F, 4'b0000, 35, 1);
`else
    run("ill_11",  4'd11, 32'h0001_0000, 32'h0001_0000, 5'd14, 32'h0000_0000, 4'b0011, 3, 0);
`endif

    // Back-pressure: 6 back-to-back ADDs (A=tag, B=100) with out_ready low for 5 cycles.
    @(posedge CLK); #1;
    out_ready = 1'b0; aluop = 4'd2; port_B = 32'd100; port_A = 32'd0; in_tag = 5'd0;
    in_valid = 1'b1; tag_n = 0; acc_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      acc = in_ready;
      if (c >= 3) begin
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_out_tag", 64'(out_tag), 64'd0);
        chk("stall_output", 64'(output_port), 64'd100);
      end
      if (c == 4) begin
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_accepted", 64'(acc_cnt), 64'd3);
      end
      @(posedge CLK);
      if (acc) begin acc_cnt++; tag_n++; end
      #1;
      port_A = 32'(tag_n); in_tag = 5'(tag_n);
    end
    out_ready = 1'b1; exp_tag = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 12 && exp_tag < 6; c++) begin
      @(negedge CLK);
      acc = in_valid && in_ready;
      if (out_valid) begin
        chk("drain_tag", 64'(out_tag), 64'(exp_tag));
        chk("drain_res", 64'(output_port), 64'(exp_tag + 100));
        if (first_c < 0) first_c = c;
        last_c = c;
        exp_tag++;
      end
      @(posedge CLK);
      if (acc) tag_n++;
      #1;
      port_A = 32'(tag_n); in_tag = 5'(tag_n);
      if (tag_n >= 6) in_valid = 1'b0;
    end
    chk("drain_count", 64'(exp_tag), 64'd6);
    chk("drain_back_to_back", 64'(last_c - first_c), 64'd5);

    // Flush with two ops in flight.
    @(posedge CLK); #1;
    out_ready = 1'b1; aluop = 4'd2; port_A = 32'd10; port_B = 32'd0; in_tag = 5'd10;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    port_A = 32'd11; in_tag = 5'd11;
    @(posedge CLK); #1;
    in_valid = 1'b0; flush = 1'b1;
    @(negedge CLK);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge CLK); #1;
    flush = 1'b0;
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (out_valid) stale++;
    end
    chk("flush_no_stale", 64'(stale), 64'd0);
    run("post_flush", 4'd2, 32'd20, 32'd5, 5'd12, 32'd25, 4'b0000, 3, 0);

    // Asynchronous reset mid-stream with a full, stalled pipe.
    @(posedge CLK); #1;
    out_ready = 1'b0; aluop = 4'd2; port_A = 32'd20; port_B = 32'd1; in_tag = 5'd20;
    in_valid = 1'b1;
    repeat (4) @(posedge CLK);
    #3;
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_output", 64'(output_port), 64'd21);
    nRST = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_output", 64'(output_port), 64'd0);
    chk("mid_rst_flags_tag", 64'({negative, overflow, zero, illegal, out_tag}), 64'd0);
    in_valid = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    run("post_rst", 4'd2, 32'd2, 32'd3, 5'd21, 32'd5, 4'b0000, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
